// File: rtl/ebob_sched.sv
// Two-requester GCD scheduler: grants one job at a time round-robin and
// solves it on a shared subtractive GCD datapath (IDLE -> CALC -> DONE).
module ebob_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clkrst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_gcd,
  output logic             res_id,
  input  logic             res_ready,
  output logic             busy,
  output logic [7:0]       jobs_done
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
  logic             id_q, id_d, last_q, last_d;
  logic [7:0]       jobs_q, jobs_d;
  logic             grant_id;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; ready never depends on the same-cycle transfer of the other side
  // beyond its own valid, and the producer holds valid/data until it transfers.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    gcd_d      = gcd_q;
    id_d       = id_q;
    last_d     = last_q;
    jobs_d     = jobs_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_id   = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    case (state_q)
      IDLE: begin
        req0_ready = req0_valid && !grant_id && !clkrst;
        req1_ready = req1_valid &&  grant_id && !clkrst;
        if (req0_ready || req1_ready) begin
          a_d     = grant_id ? req1_a : req0_a;
          b_d     = grant_id ? req1_b : req0_b;
          id_d    = grant_id;
          last_d  = grant_id;
          state_d = CALC;
        end
      end
      CALC: begin
        if (a_q == '0) begin
          gcd_d   = b_q;
          state_d = DONE;
        end else if (b_q == '0) begin
          gcd_d   = a_q;
          state_d = DONE;
        end else if (a_q == b_q) begin
          gcd_d   = a_q;
          state_d = DONE;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
          jobs_d  = jobs_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clkrst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;  // req0 wins the first contended grant
      jobs_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      id_q    <= id_d;
      last_q  <= last_d;
      jobs_q  <= jobs_d;
    end
  end

  assign res_valid = (state_q == DONE);
  assign res_gcd   = gcd_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);
  assign jobs_done = jobs_q;

endmodule

// File: tb/tb_ebob_sched.sv
// Directed and randomized checks of ebob_sched against a plain GCD /
// round-robin reference model kept in the bench.
module tb_ebob_sched;
  localparam int W = 4;

  logic         clk, clkrst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_id, res_ready, busy;
  logic [W-1:0] res_gcd;
  logic [7:0]   jobs_done;

  ebob_sched #(.WIDTH(W)) dut (
    .clk(clk), .clkrst(clkrst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_gcd(res_gcd), .res_id(res_id), .res_ready(res_ready),
    .busy(busy), .jobs_done(jobs_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic         m_last;
  logic [7:0]   m_jobs;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a[W-1:0];
  endfunction

  function automatic int ref_steps(input int a, input int b);
    int k = 0;
    while (a != 0 && b != 0 && a != b) begin
      if (a > b) a = a - b;
      else       b = b - a;
      k++;
    end
    return k;
  endfunction

  // Caller sets request inputs at a negedge with the DUT idle.
  task automatic serve(input int hold, input bit keep);
    logic         w, saw_id;
    logic [W-1:0] ea, eb, eg;
    int           n, k;
    #1;
    w = (req0_valid && req1_valid) ? ~m_last : req1_valid;
    chk("req0_ready_grant", req0_ready, req0_valid && !w);
    chk("req1_ready_grant", req1_ready, req1_valid && w);
    ea = w ? req1_a : req0_a;
    eb = w ? req1_b : req0_b;
    exp_q.push_back(ref_gcd(int'(ea), int'(eb)));
    k = ref_steps(int'(ea), int'(eb));
    res_ready = (hold == 0);
    @(posedge clk);
    m_last = w;
    #1;
    if (!keep) begin
      if (w) req1_valid = 1'b0;
      else   req0_valid = 1'b0;
    end
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (res_valid !== 1'b1 && n < 64);
    chk("latency", n, k + 1);
    @(negedge clk);
    eg = exp_q.pop_front();
    saw_id = w;
    chk("res_gcd", res_gcd, eg);
    chk("res_id", res_id, saw_id);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_gcd", res_gcd, eg);
      chk("hold_id", res_id, saw_id);
      chk("hold_busy", busy, 1'b1);
      chk("hold_rdy0", req0_ready, 1'b0);
      chk("hold_rdy1", req1_ready, 1'b0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    m_jobs = m_jobs + 8'd1;
    chk("post_valid", res_valid, 1'b0);
    chk("post_busy", busy, 1'b0);
    chk("jobs_done", jobs_done, m_jobs);
  endtask

  initial begin
    logic saw;
    clkrst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd3;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    m_last = 1'b1; m_jobs = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_rdy0", req0_ready, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_gcd", res_gcd, 0);
    chk("rst_id", res_id, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_jobs", jobs_done, 0);
    req0_valid = 1'b0; clkrst = 1'b0;
    @(negedge clk);

    // single job
    req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd10;
    serve(0, 1'b0);

    // contention: both held valid, grants alternate
    req0_valid = 1'b1; req0_a = 4'd12; req0_b = 4'd8;
    req1_valid = 1'b1; req1_a = 4'd9;  req1_b = 4'd6;
    for (int i = 0; i < 4; i++) serve(0, 1'b1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // zero operands
    req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd7; serve(0, 1'b0);
    req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd0; serve(0, 1'b0);
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd0; serve(0, 1'b0);

    // result backpressure
    req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd1;
    serve(5, 1'b0);

    // reset in the middle of CALC
    req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd1;
    #1 chk("mid_rdy0", req0_ready, 1'b1);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    clkrst = 1'b1; req1_valid = 1'b1;
    #1 chk("rst_mid_rdy1", req1_ready, 1'b0);
    @(negedge clk);
    clkrst = 1'b0; req1_valid = 1'b0;
    m_last = 1'b1; m_jobs = 8'd0;
    chk("mid_valid", res_valid, 1'b0);
    chk("mid_gcd", res_gcd, 0);
    chk("mid_id", res_id, 0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_jobs", jobs_done, 0);
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw = saw | res_valid;
    end
    chk("mid_no_result", saw, 1'b0);
    req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd4;
    serve(0, 1'b0);

    // randomized jobs
    for (int i = 0; i < 40; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = req0_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      req0_a = W'($urandom_range(0, 15)); req0_b = W'($urandom_range(0, 15));
      req1_a = W'($urandom_range(0, 15)); req1_b = W'($urandom_range(0, 15));
      serve($urandom_range(0, 2), 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // counter wrap
    while (m_jobs != 8'd255) begin
      req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd1;
      serve(0, 1'b0);
    end
    chk("wrap_255", jobs_done, 8'd255);
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd0;
    serve(0, 1'b0);
    chk("wrap_0", jobs_done, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ebob_sched.md
EBOB_SCHED -- requirements
Module: ebob_sched

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 clkrst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 holds a job.
REQ-005 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-006 req0_ready  output  1  requester 0 job accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready: same as REQ-004..006, for requester 1.
REQ-008 res_valid  output  1  result available.
REQ-009 res_gcd  output  WIDTH  greatest common divisor of accepted operands.
REQ-010 res_id  output  1  index of the requester that owns the result.
REQ-011 res_ready  input  1  consumer takes result.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 jobs_done  output  8  count of completed result handshakes, wraps at 255 to 0.

Function
REQ-014 FSM states: IDLE, CALC, DONE; one internal subtractive GCD datapath shared by both requesters.
REQ-015 IDLE grant: only reqX valid -> grant X; both valid -> grant the requester not served last; last-served pointer resets to 1, so req0 wins first.
REQ-016 reqX_ready is combinational: high only in IDLE, for the granted requester, and only while its valid is high; at most one ready is high per cycle.
REQ-017 Accept edge (valid&&ready): latch a, b and id; update last-served pointer; go to CALC.
REQ-018 CALC, one step per edge, evaluated in this priority order:
- a==0 -> gcd=b, go to DONE.
- b==0 -> gcd=a, go to DONE.
- a==b -> gcd=a, go to DONE.
- a>b -> a=a-b, stay in CALC.
- else -> b=b-a, stay in CALC.
REQ-019 Arithmetic is unsigned WIDTH-bit; a subtraction never underflows; gcd(0,0)=0.
REQ-020 Latency: a job needing k subtractions raises res_valid on edge k+1 after the accept edge; a zero operand gives k=0.
REQ-021 DONE: res_valid=1; res_gcd and res_id hold stable until res_valid&&res_ready.
REQ-022 Result handshake edge: go to IDLE, res_valid=0, jobs_done increments.
REQ-023 In CALC and DONE both reqX_ready are low; requests wait, and requesters hold valid and data until ready.
REQ-024 No bypass: the earliest next accept is the cycle after IDLE is re-entered.
REQ-025 res_ready is ignored outside DONE.
REQ-026 A requester that drops valid before ready loses its slot; the grant is re-evaluated every IDLE cycle.

Reset
REQ-027 clkrst high on an edge forces, in any state including mid-CALC:
- state=IDLE, res_valid=0, res_gcd=0, res_id=0
- busy=0, jobs_done=0, last-served pointer=1
- internal operands=0; any in-flight job is discarded with no result.
REQ-028 During reset both reqX_ready are low; reset dominates all handshakes on the same edge.

Verification
REQ-029 Single job: req0 (15,10), res_ready=1 -> accept; res_valid rises on the 3rd edge after accept; res_gcd=5, res_id=0, jobs_done=1.
REQ-030 Contention after reset: req0 (12,8) and req1 (9,6) both held valid -> req0 served first (gcd 4, id 0), then req1 (gcd 3, id 1); with both still valid, grants keep alternating 0,1,0,1.
REQ-031 Zero operands: (0,7) -> res_gcd=7 one edge after accept; (0,0) -> 0; (9,0) -> 9.
REQ-032 Backpressure: req1 (15,1) with res_ready low for 5 cycles after res_valid -> res_gcd=1 and res_id=1 stable, both readys low, busy=1; handshake then releases.
REQ-033 Reset mid-CALC: req0 (15,1), clkrst pulsed 4 edges after accept -> all outputs 0, no result emitted; next job (6,4) -> res_gcd=2.
REQ-034 Counter wrap: 256 completed jobs -> jobs_done reads 255 then 0.
